ram_dma: RTL and testbench

RAM_DMA -- requirements
Module: ram_dma

---
 rtl/ram_dma_pkg.sv | 16 +
 rtl/ram_dma.sv | 145 ++++++++++++++
 tb/tb_ram_dma.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg -- shared core defines for the RAM-to-RAM DMA engine.
// Holds the controller state encoding and the word/byte-enable constants
// used by ram_dma.
package ram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  SEL_ALL    = 4'hF;

endpackage

// File: rtl/ram_dma.sv
// ram_dma -- word-at-a-time RAM copy engine.
//
// A start pulse in IDLE latches word-aligned source/destination addresses and
// a word count. Each word is moved in two cycles: RD presents the source
// address to a synchronous-read RAM, WR writes the returned data to the
// destination. A one-cycle DONE state pulses done_o. abort_i returns to IDLE
// from any busy state without a done pulse.
//
// Optional feature (macro RAM_DMA_FILL_EN): adds fill_i / pattern_i. When fill
// is latched at start, RD is skipped and pattern is written every cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i, abort_i  transfer control
//   src_i, dst_i      byte addresses (bits [1:0] ignored)
//   len_i             word count
//   busy_o, done_o    status; remain_o = words not yet written
//   addr_o, data_o, sel_o, we_o  RAM request; data_i = RAM read data
//   fill_i, pattern_i (RAM_DMA_FILL_EN only) fill mode and fill word
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
`ifdef RAM_DMA_FILL_EN
  input  logic             fill_i,
  input  logic [31:0]      pattern_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] remain_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_o,
  output logic [3:0]       sel_o,
  output logic             we_o,
  input  logic [31:0]      data_i
);

  state_t           state, state_nxt;
  logic [31:0]      src_q, dst_q;
  logic [LEN_W-1:0] remain_q;
  logic             load, advance;
  logic             fill_start, fill_mode;
  logic [31:0]      pattern_w;

`ifdef RAM_DMA_FILL_EN
  logic        fill_q;
  logic [31:0] pattern_q;

  assign fill_start = fill_i;
  assign fill_mode  = fill_q;
  assign pattern_w  = pattern_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else if (load) begin
      fill_q    <= fill_i;
      pattern_q <= pattern_i;
    end
  end
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
  assign pattern_w  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    addr_o    = '0;
    data_o    = '0;
    sel_o     = 4'h0;
    we_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          load = 1'b1;
          if (len_i == '0) state_nxt = DONE;
          else             state_nxt = fill_start ? WR : RD;
        end
      end
      RD: begin
        busy_o    = 1'b1;
        addr_o    = src_q;
        state_nxt = abort_i ? IDLE : WR;
      end
      WR: begin
        busy_o  = 1'b1;
        addr_o  = dst_q;
        data_o  = fill_mode ? pattern_w : data_i;
        we_o    = 1'b1;
        sel_o   = SEL_ALL;
        // The write is already on the bus this cycle, so an abort still
        // lets the pointers and count account for it.
        advance = 1'b1;
        if (abort_i)                     state_nxt = IDLE;
        else if (remain_q > LEN_W'(1))   state_nxt = fill_mode ? WR : RD;
        else                             state_nxt = DONE;
      end
      DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
    end else if (load) begin
      src_q    <= {src_i[31:2], 2'b00};
      dst_q    <= {dst_i[31:2], 2'b00};
      remain_q <= len_i;
    end else if (advance) begin
      // 32-bit adds wrap naturally modulo 2^32.
      src_q    <= src_q + 32'(WORD_BYTES);
      dst_q    <= dst_q + 32'(WORD_BYTES);
      remain_q <= remain_q - LEN_W'(1);
    end
  end

  assign remain_o = remain_q;

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma -- directed bench for ram_dma with a synchronous-read RAM model.
module tb_ram_dma;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i, abort_i;
  logic [31:0]      src_i, dst_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o, done_o, we_o;
  logic [LEN_W-1:0] remain_o;
  logic [31:0]      addr_o, data_o, data_i;
  logic [3:0]       sel_o;
`ifdef RAM_DMA_FILL_EN
  logic             fill_i;
  logic [31:0]      pattern_i;
`endif

  always #5 clk = ~clk;

  ram_dma #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .src_i    (src_i),
    .dst_i    (dst_i),
    .len_i    (len_i),
`ifdef RAM_DMA_FILL_EN
    .fill_i   (fill_i),
    .pattern_i(pattern_i),
`endif
    .busy_o   (busy_o),
    .done_o   (done_o),
    .remain_o (remain_o),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .sel_o    (sel_o),
    .we_o     (we_o),
    .data_i   (data_i)
  );

  // RAM model: 1024 words, address bits [11:2], one-cycle read latency.
  logic [31:0] mem [0:1023];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_addr = '0;
  logic [31:0] tb_wdata = '0;
  int unsigned wr_count = 0;

  always @(posedge clk) begin
    if (tb_we)     mem[tb_addr] <= tb_wdata;
    else if (we_o) mem[addr_o[11:2]] <= data_o;
    if (we_o) wr_count <= wr_count + 1;
    data_i <= mem[addr_o[11:2]];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic mem_wr(input logic [31:0] byte_addr, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = byte_addr[11:2]; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n);
    @(negedge clk);
    src_i = s; dst_i = d; len_i = n; start_i = 1'b1;
    @(negedge clk);   // now at cycle 1
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (busy_o) begin
      errors++;
      $display("FAIL %s_timeout: busy_o still 1 after %0d cycles", name, c);
    end
  endtask

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      seed;
    bit               poke;
    int               exp_done;
    int               exp_busy;
    int               exp_wr;
  } row_t;

  row_t rows [4];

  initial begin
    int          done_cyc, done_cnt, busy_cnt, bad_out, ended;
    int unsigned wr0;
    logic        done_seen;
    logic [31:0] dbase;

    rows[0] = '{32'h100, 32'h200, 16'd4, 32'd1,        1'b0, 9, 9, 4};
    rows[1] = '{32'h300, 32'h383, 16'd1, 32'hA5A50000, 1'b0, 3, 3, 1};
    rows[2] = '{32'h010, 32'h020, 16'd0, 32'd0,        1'b0, 1, 1, 0};
    rows[3] = '{32'h402, 32'h500, 16'd3, 32'h77,       1'b1, 7, 7, 3};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    src_i = '0; dst_i = '0; len_i = '0;
`ifdef RAM_DMA_FILL_EN
    fill_i = 1'b0; pattern_i = '0;
`endif

    // Outputs must be zero under reset before any clock edge.
    #2;
    check("rst_busy",   {31'd0, busy_o}, 32'd0);
    check("rst_done",   {31'd0, done_o}, 32'd0);
    check("rst_we",     {31'd0, we_o},   32'd0);
    check("rst_sel",    {28'd0, sel_o},  32'd0);
    check("rst_addr",   addr_o,          32'd0);
    check("rst_data",   data_o,          32'd0);
    check("rst_remain", {16'd0, remain_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Table-driven copies.
    for (int r = 0; r < 4; r++) begin
      dbase = {rows[r].dst[31:2], 2'b00};
      for (int i = 0; i < int'(rows[r].len); i++)
        mem_wr({rows[r].src[31:2], 2'b00} + 32'(4 * i), rows[r].seed + 32'(i));
      for (int i = 0; i <= int'(rows[r].len); i++)
        mem_wr(dbase + 32'(4 * i), 32'd0);

      wr0 = wr_count;
      start_xfer(rows[r].src, rows[r].dst, rows[r].len);
      done_cyc = -1; done_cnt = 0; busy_cnt = 0; bad_out = 0; ended = 0;
      for (int c = 1; c <= 100; c++) begin
        if (!busy_o) begin ended = 1; break; end
        busy_cnt++;
        if (done_o) begin done_cnt++; done_cyc = c; end
        if (!we_o && data_o != 32'd0) bad_out++;
        if (!we_o && sel_o != 4'h0)   bad_out++;
        if (we_o && sel_o != 4'hF)    bad_out++;
        if (rows[r].poke && c == 2) begin
          start_i = 1'b1; len_i = 16'd1; src_i = 32'h0;
        end else begin
          start_i = 1'b0;
        end
        @(negedge clk);
      end
      start_i = 1'b0;
      check($sformatf("row%0d_ended", r),    ended,                 32'd1);
      check($sformatf("row%0d_done_cyc", r), done_cyc,              rows[r].exp_done);
      check($sformatf("row%0d_done_cnt", r), done_cnt,              32'd1);
      check($sformatf("row%0d_busy", r),     busy_cnt,              rows[r].exp_busy);
      check($sformatf("row%0d_writes", r),   wr_count - wr0,        rows[r].exp_wr);
      check($sformatf("row%0d_remain", r),   {16'd0, remain_o},     32'd0);
      check($sformatf("row%0d_idle_outs", r), bad_out,              32'd0);
      for (int i = 0; i < int'(rows[r].len); i++)
        check($sformatf("row%0d_word%0d", r, i),
              mem[dbase[11:2] + 10'(i)], rows[r].seed + 32'(i));
      check($sformatf("row%0d_no_overrun", r), mem[dbase[11:2] + 10'(rows[r].len)], 32'd0);
    end

    // Abort at cycle 3 (second RD) of an 8-word copy: one word written.
    wr0 = wr_count;
    start_xfer(32'h600, 32'h700, 16'd8);
    done_seen = done_o;
    @(negedge clk); done_seen |= done_o;
    @(negedge clk); done_seen |= done_o;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy_low", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      done_seen |= done_o;
      @(negedge clk);
    end
    check("abort_no_done", {31'd0, done_seen}, 32'd0);
    check("abort_le2_writes", {31'd0, (wr_count - wr0) <= 2}, 32'd1);
    check("abort_remain_hold", {16'd0, remain_o}, 32'd7);

    // Source address wraps from 0xFFFFFFFC to 0x00000000.
    mem_wr(32'hFFFFFFFC, 32'h11);
    mem_wr(32'h00000000, 32'h22);
    start_xfer(32'hFFFFFFFC, 32'h800, 16'd2);
    check("wrap_rd0_addr", addr_o, 32'hFFFFFFFC);
    @(negedge clk); @(negedge clk);
    check("wrap_rd1_addr", addr_o, 32'h00000000);
    wait_idle("wrap");
    check("wrap_word0", mem[10'h200], 32'h11);
    check("wrap_word1", mem[10'h201], 32'h22);

    // Reset asserted during the second WR of a 4-word copy.
    for (int i = 0; i < 4; i++) mem_wr(32'h900 + 32'(4 * i), 32'd0);
    start_xfer(32'h100, 32'h900, 16'd4);
    @(negedge clk); @(negedge clk); @(negedge clk);   // cycle 4: WR of word 1
    check("midrst_in_wr", {31'd0, we_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, busy_o},   32'd0);
    check("midrst_we",     {31'd0, we_o},     32'd0);
    check("midrst_addr",   addr_o,            32'd0);
    check("midrst_data",   data_o,            32'd0);
    check("midrst_sel",    {28'd0, sel_o},    32'd0);
    check("midrst_remain", {16'd0, remain_o}, 32'd0);
    wr0 = wr_count;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("midrst_no_writes", wr_count - wr0, 32'd0);
    check("midrst_word0", mem[10'h240], 32'd1);
    check("midrst_word1", mem[10'h241], 32'd0);

`ifdef RAM_DMA_FILL_EN
    // Fill mode: WR-only, one word per cycle.
    wr0 = wr_count;
    done_cyc = -1;
    @(negedge clk);
    src_i = 32'h0; dst_i = 32'h40; len_i = 16'd3; start_i = 1'b1;
    fill_i = 1'b1; pattern_i = 32'hDEADBEEF;
    @(negedge clk);
    start_i = 1'b0; fill_i = 1'b0; pattern_i = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("fill_we_c%0d", c), {31'd0, we_o}, 32'd1);
      @(negedge clk);
    end
    check("fill_done_c4", {31'd0, done_o}, 32'd1);
    @(negedge clk);
    check("fill_idle_c5", {31'd0, busy_o}, 32'd0);
    check("fill_writes", wr_count - wr0, 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("fill_word%0d", i), mem[10'h10 + 10'(i)], 32'hDEADBEEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
